// File: rtl/proc_pkg.sv
// Shared definitions for the two-stage 16-bit core: opcodes, R-type function codes
// and the sign-extension helpers used by decode.
package proc_pkg;

  localparam int XLEN = 16;
  localparam int NREG = 8;
  localparam int RAW  = 3;

  typedef enum logic [4:0] {
    OP_HALT  = 5'b00000,
    OP_NOP   = 5'b00001,
    OP_J     = 5'b00100,
    OP_ADDI  = 5'b01000,
    OP_BEQZ  = 5'b01100,
    OP_ST    = 5'b10000,
    OP_LD    = 5'b10001,
    OP_LBI   = 5'b11000,
    OP_RTYPE = 5'b11011
  } opcode_e;

  typedef enum logic [1:0] {
    FN_ADD  = 2'b00,
    FN_SUB  = 2'b01,
    FN_XOR  = 2'b10,
    FN_ANDN = 2'b11
  } func_e;

  function automatic logic [XLEN-1:0] sext5(input logic [4:0] v);
    return {{(XLEN-5){v[4]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext8(input logic [7:0] v);
    return {{(XLEN-8){v[7]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext11(input logic [10:0] v);
    return {{(XLEN-11){v[10]}}, v};
  endfunction

endpackage

// File: rtl/proc_if.sv
// Instruction/data memory bus between the core (master) and external memories (slave).
// Purely combinational wires; memories answer in the same cycle, no backpressure.
interface proc_if;
  import proc_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ren;
  logic            dmem_wen;

  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_ren, dmem_wen,
    input  imem_data, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_ren, dmem_wen,
    output imem_data, dmem_rdata
  );

endinterface

// File: rtl/proc_regfile.sv
// 8x16 register file, two combinational read ports and one write port on the rising edge.
// Reads see the pre-write value in the write cycle; no backpressure.
module proc_regfile
  import proc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  ra0,
  input  logic [RAW-1:0]  ra1,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1,
  input  logic            we,
  input  logic [RAW-1:0]  wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd0 = regs_q[ra0];
  assign rd1 = regs_q[ra1];

endmodule

// File: rtl/proc_hier_top.sv
// Two-stage (IF | ID/EX/MEM/WB) 16-bit processor with per-cycle trace outputs.
// One instruction per clock; taken branches cost one flushed slot; HALT freezes the pipe.
module proc_hier_top
  import proc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  proc_if.master      mem,
  output logic [15:0] pc,
  output logic [15:0] instr_ifid,
  output logic [15:0] nxt_pc_ifid,
  output logic        valid_ifid,
  output logic        reg_write,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data,
  output logic        halt,
  output logic [31:0] cycle_count
);

  logic [15:0] pc_q, pc_d, instr_q, instr_d, nxt_pc_q, nxt_pc_d;
  logic        valid_q, valid_d, halt_q, halt_d;
  logic [31:0] cycle_q, cycle_d;

  opcode_e     op;
  func_e       fn;
  logic [2:0]  rs_a, rt_a, rd_a;
  logic [15:0] rs_v, rt_v, alu_addr, target;
  logic        en, take, halt_now, ren, wen, wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_dat;

  assign op       = opcode_e'(instr_q[15:11]);
  assign fn       = func_e'(instr_q[1:0]);
  assign rs_a     = instr_q[10:8];
  assign rt_a     = instr_q[7:5];
  assign rd_a     = instr_q[4:2];
  assign en       = valid_q & ~halt_q;
  assign alu_addr = rs_v + sext5(instr_q[4:0]);

  proc_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra0 (rs_a),
    .ra1 (rt_a),
    .rd0 (rs_v),
    .rd1 (rt_v),
    .we  (wr_en),
    .wa  (wr_addr),
    .wd  (wr_dat)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = rt_a;
    wr_dat   = alu_addr;
    ren      = 1'b0;
    wen      = 1'b0;
    take     = 1'b0;
    halt_now = 1'b0;
    target   = nxt_pc_q + sext8(instr_q[7:0]);
    case (op)
      OP_HALT: halt_now = en;
      OP_ADDI: wr_en = en;
      OP_LD: begin
        wr_en  = en;
        ren    = en;
        wr_dat = mem.dmem_rdata;
      end
      OP_ST: wen = en;
      OP_LBI: begin
        wr_en   = en;
        wr_addr = rs_a;
        wr_dat  = sext8(instr_q[7:0]);
      end
      OP_RTYPE: begin
        wr_en   = en;
        wr_addr = rd_a;
        case (fn)
          FN_ADD:  wr_dat = rs_v + rt_v;
          FN_SUB:  wr_dat = rt_v - rs_v;
          FN_XOR:  wr_dat = rs_v ^ rt_v;
          FN_ANDN: wr_dat = rs_v & ~rt_v;
          default: wr_dat = rs_v + rt_v;
        endcase
      end
      OP_BEQZ: take = en & (rs_v == 16'h0000);
      OP_J: begin
        take   = en;
        target = nxt_pc_q + sext11(instr_q[10:0]);
      end
      default: ;
    endcase
  end

  // halt is visible in the same cycle the HALT sits in stage 2, and it freezes fetch then.
  assign halt = halt_q | halt_now;

  always_comb begin
    pc_d     = pc_q + 16'd2;
    instr_d  = mem.imem_data;
    nxt_pc_d = pc_q + 16'd2;
    valid_d  = 1'b1;
    halt_d   = halt;
    cycle_d  = cycle_q + 32'd1;
    if (halt) begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      nxt_pc_d = nxt_pc_q;
      valid_d  = valid_q;
    end else if (take) begin
      pc_d    = target;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      nxt_pc_q <= '0;
      valid_q  <= 1'b0;
      halt_q   <= 1'b0;
      cycle_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      nxt_pc_q <= nxt_pc_d;
      valid_q  <= valid_d;
      halt_q   <= halt_d;
      cycle_q  <= cycle_d;
    end
  end

  assign mem.imem_addr  = pc_q;
  assign mem.dmem_addr  = alu_addr;
  assign mem.dmem_wdata = rt_v;
  assign mem.dmem_ren   = ren;
  assign mem.dmem_wen   = wen;

  assign pc          = pc_q;
  assign instr_ifid  = instr_q;
  assign nxt_pc_ifid = nxt_pc_q;
  assign valid_ifid  = valid_q;
  assign reg_write   = wr_en;
  assign write_reg   = wr_addr;
  assign write_data  = wr_dat;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_proc_hier_top.sv
// Directed-program bench for proc_hier_top with behavioural instruction/data memories.
module tb_proc_hier_top;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  proc_if bus ();

  logic [15:0] pc, instr_ifid, nxt_pc_ifid, write_data;
  logic        valid_ifid, reg_write, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;

  logic [15:0] imem [0:255];
  logic [15:0] dmem [0:255];

  assign bus.imem_data  = imem[bus.imem_addr[8:1]];
  assign bus.dmem_rdata = dmem[bus.dmem_addr[8:1]];

  always @(posedge clk) begin
    if (bus.dmem_wen) dmem[bus.dmem_addr[8:1]] <= bus.dmem_wdata;
  end

  proc_hier_top dut (
    .clk         (clk),
    .rst         (rst),
    .mem         (bus.master),
    .pc          (pc),
    .instr_ifid  (instr_ifid),
    .nxt_pc_ifid (nxt_pc_ifid),
    .valid_ifid  (valid_ifid),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .halt        (halt),
    .cycle_count (cycle_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  localparam logic [15:0] NOP_I  = 16'h0800;
  localparam logic [15:0] HALT_I = 16'h0000;

  function automatic logic [15:0] lbi(input logic [2:0] rs, input logic [7:0] imm);
    return {5'b11000, rs, imm};
  endfunction
  function automatic logic [15:0] addi(input logic [2:0] rs, input logic [2:0] rt, input logic [4:0] imm);
    return {5'b01000, rs, rt, imm};
  endfunction
  function automatic logic [15:0] st(input logic [2:0] rs, input logic [2:0] rt, input logic [4:0] imm);
    return {5'b10000, rs, rt, imm};
  endfunction
  function automatic logic [15:0] ld(input logic [2:0] rs, input logic [2:0] rt, input logic [4:0] imm);
    return {5'b10001, rs, rt, imm};
  endfunction
  function automatic logic [15:0] rtype(input logic [2:0] rs, input logic [2:0] rt,
                                        input logic [2:0] rd, input logic [1:0] f);
    return {5'b11011, rs, rt, rd, f};
  endfunction
  function automatic logic [15:0] beqz(input logic [2:0] rs, input logic [7:0] imm);
    return {5'b01100, rs, imm};
  endfunction
  function automatic logic [15:0] jmp(input logic [10:0] imm);
    return {5'b00100, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = NOP_I;
      dmem[i] = 16'h0000;
    end
  endtask

  // Reset is released at a falling edge; the next rising edge is the first clock.
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and sequential fetch of NOPs
    clear_mem();
    do_reset();
    check("rst_pc", pc, 16'h0000);
    check("rst_valid", valid_ifid, 1'b0);
    check("rst_instr", instr_ifid, 16'h0000);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_strobes", {reg_write, bus.dmem_ren, bus.dmem_wen, halt}, 4'b0000);
    step();
    check("nop_pc1", pc, 16'h0002);
    check("nop_valid1", valid_ifid, 1'b1);
    check("nop_nxt1", nxt_pc_ifid, 16'h0002);
    check("nop_cycle1", cycle_count, 32'd1);
    step();
    check("nop_pc2", pc, 16'h0004);
    check("nop_cycle2", cycle_count, 32'd2);
    check("nop_regw", reg_write, 1'b0);

    // LBI / R-type / ADDI
    clear_mem();
    imem[0] = lbi(3'd1, 8'h05);
    imem[1] = lbi(3'd2, 8'hFD);
    imem[2] = rtype(3'd1, 3'd2, 3'd3, 2'b00);
    imem[3] = rtype(3'd1, 3'd2, 3'd5, 2'b01);
    imem[4] = rtype(3'd1, 3'd2, 3'd6, 2'b10);
    imem[5] = addi(3'd1, 3'd7, 5'h1F);
    imem[6] = rtype(3'd1, 3'd2, 3'd4, 2'b11);
    do_reset();
    step();
    check("lbi1", {reg_write, write_reg, write_data}, {1'b1, 3'd1, 16'h0005});
    step();
    check("lbi2", {reg_write, write_reg, write_data}, {1'b1, 3'd2, 16'hFFFD});
    step();
    check("add", {reg_write, write_reg, write_data}, {1'b1, 3'd3, 16'h0002});
    step();
    check("sub", {reg_write, write_reg, write_data}, {1'b1, 3'd5, 16'hFFF8});
    step();
    check("xor", {reg_write, write_reg, write_data}, {1'b1, 3'd6, 16'hFFF8});
    step();
    check("addi", {reg_write, write_reg, write_data}, {1'b1, 3'd7, 16'h0004});
    step();
    check("andn", {reg_write, write_reg, write_data}, {1'b1, 3'd4, 16'h0000});

    // Store then load through external data memory
    clear_mem();
    imem[0] = lbi(3'd1, 8'h10);
    imem[1] = lbi(3'd2, 8'h55);
    imem[2] = st(3'd1, 3'd2, 5'd2);
    imem[3] = ld(3'd1, 3'd4, 5'd2);
    do_reset();
    step();
    step();
    check("pre_st_wen", bus.dmem_wen, 1'b0);
    step();
    check("st_wen", {bus.dmem_wen, bus.dmem_ren, reg_write}, 3'b100);
    check("st_addr", bus.dmem_addr, 16'h0012);
    check("st_wdata", bus.dmem_wdata, 16'h0055);
    step();
    check("ld_ren", {bus.dmem_ren, bus.dmem_wen}, 2'b10);
    check("ld_wb", {reg_write, write_reg, write_data}, {1'b1, 3'd4, 16'h0055});

    // BEQZ taken (flush) then BEQZ not taken (fall through)
    clear_mem();
    imem[0] = lbi(3'd1, 8'h00);
    imem[1] = beqz(3'd1, 8'h04);
    imem[2] = lbi(3'd3, 8'h77);
    imem[3] = lbi(3'd3, 8'h66);
    imem[4] = lbi(3'd4, 8'h11);
    imem[5] = beqz(3'd4, 8'h04);
    imem[6] = lbi(3'd5, 8'h22);
    do_reset();
    step();
    step();
    check("beqz_regw", reg_write, 1'b0);
    step();
    check("beqz_flush", {valid_ifid, reg_write}, 2'b00);
    check("beqz_pc", pc, 16'h0008);
    step();
    check("beqz_tgt", {valid_ifid, reg_write, write_reg, write_data}, {2'b11, 3'd4, 16'h0011});
    step();
    check("bnz_pc", pc, 16'h000C);
    step();
    check("bnz_fall", {valid_ifid, reg_write, write_reg, write_data}, {2'b11, 3'd5, 16'h0022});
    check("bnz_pc2", pc, 16'h000E);

    // J #-2 at address 0 loops on itself
    clear_mem();
    imem[0] = jmp(11'h7FE);
    do_reset();
    check("j_pc0", pc, 16'h0000);
    step();
    check("j_pc1", {pc, 15'h0, valid_ifid}, {16'h0002, 15'h0, 1'b1});
    step();
    check("j_pc2", {pc, 15'h0, valid_ifid}, {16'h0000, 15'h0, 1'b0});
    step();
    check("j_pc3", {pc, 15'h0, valid_ifid}, {16'h0002, 15'h0, 1'b1});
    step();
    check("j_pc4", {pc, 15'h0, valid_ifid}, {16'h0000, 15'h0, 1'b0});

    // HALT freezes the pipe; async reset clears it
    clear_mem();
    imem[0] = lbi(3'd1, 8'h07);
    imem[1] = HALT_I;
    imem[2] = addi(3'd1, 3'd1, 5'd1);
    do_reset();
    step();
    check("pre_halt", halt, 1'b0);
    step();
    check("halt_now", halt, 1'b1);
    check("halt_pc", pc, 16'h0004);
    step();
    check("halt_hold", {halt, reg_write, bus.dmem_wen}, 3'b100);
    check("halt_pc_frz", pc, 16'h0004);
    step();
    step();
    check("halt_hold2", {halt, reg_write}, 2'b10);
    check("halt_pc_frz2", pc, 16'h0004);
    check("halt_r1", dut.u_rf.regs_q[1], 16'h0007);
    check("halt_cycle", cycle_count, 32'd5);
    rst = 1'b0;
    #1;
    check("arst_halt", halt, 1'b0);
    check("arst_pc", pc, 16'h0000);
    check("arst_cycle", cycle_count, 32'd0);
    check("arst_r1", dut.u_rf.regs_q[1], 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_hier_top.md
Name: proc_hier_top

Overview:
- Top of a 16-bit, 8-register, two-stage (IF | ID/EX/MEM/WB) pipelined processor.
- Contains the fetch logic, IF/ID pipeline register, register file, ALU, control and a free-running cycle counter.
- Instruction and data memories are external.
- Exposes per-cycle trace signals (PC, instruction, register write, memory access, halt) for the simulation logger.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  16  fetch address (= pc)
- imem_data  in  16  instruction at imem_addr, combinational
- dmem_addr  out  16  data address (ALU result)
- dmem_wdata  out  16  store data
- dmem_rdata  in  16  load data, combinational
- dmem_ren  out  1  load in stage 2
- dmem_wen  out  1  store in stage 2; memory writes on rising edge
- pc  out  16  current fetch PC
- instr_ifid  out  16  IF/ID instruction
- nxt_pc_ifid  out  16  IF/ID PC+2
- valid_ifid  out  1  IF/ID holds a valid instruction
- reg_write  out  1  register file written this cycle
- write_reg  out  3  destination register
- write_data  out  16  writeback value
- halt  out  1  HALT reached stage 2 (sticky)
- cycle_count  out  32  cycles since reset

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; IF/ID cleared (valid=0, instr=0, nxt_pc=0).
  - All 8 registers=0; halt=0; cycle_count=0.
  - All strobes (reg_write, dmem_ren, dmem_wen) are 0.
- Reset deassertion mid-program restarts cleanly from RESET_PC.
- cycle_count increments every clock while not in reset; it wraps at 2^32.
- IF stage:
  - Fetch imem_data at pc.
  - Each clock, IF/ID <= {instr, pc+2, valid=1} and pc <= pc+2 (16-bit wrap).
- Stage 2 decodes IF/ID when valid_ifid=1. All enables are gated by valid_ifid & ~halt.
- Encoding: opcode=instr[15:11], Rs=[10:8], Rt=[7:5].
  - 00000 HALT: halt<=1.
  - 00001 NOP.
  - 01000 ADDI: R[7:5] = Rs + sext(instr[4:0]).
  - 10001 LD: R[7:5] = dmem_rdata, with dmem_addr = Rs + sext(imm5); dmem_ren=1.
  - 10000 ST: mem[Rs + sext(imm5)] = R[7:5]; dmem_wen=1; dmem_wdata = R[7:5].
  - 11000 LBI: R[10:8] = sext(instr[7:0]).
  - 11011 R-type, Rd=[4:2], func=[1:0]:
    - 00 Rs+Rt
    - 01 Rt-Rs
    - 10 Rs^Rt
    - 11 Rs&~Rt
  - 01100 BEQZ: if Rs==0, target = nxt_pc_ifid + sext(instr[7:0]).
  - 00100 J: target = nxt_pc_ifid + sext(instr[10:0]), always taken.
  - Any other opcode executes as NOP.
- Arithmetic is 16-bit, two's complement; overflow is discarded.
- Register file: 2 combinational reads, 1 write on the rising edge.
- A read of the register being written in the same cycle returns the old value. No hazard arises because there is one execute stage.
- Taken branch/jump:
  - pc <= target.
  - IF/ID valid <= 0 (flush the fetched instruction): 1-cycle penalty.
- HALT, in stage 2 and valid:
  - halt asserts that cycle (combinationally) and stays 1 until reset.
  - pc and IF/ID freeze; no further reg or memory writes.
- Simultaneous HALT and flushed slot: a flushed (invalid) HALT has no effect.
- Trace outputs are combinational from stage-2 state.

Decomposition:
- Package proc_pkg: opcode constants, R-type func codes, sext helper widths.
- One natural sub-module: proc_regfile (8x16, 2R1W, async active-low reset).

Test Plan:
- Reset: hold rst=0 then release; imem all NOP → pc=0,2,4…; valid_ifid=0 in the first cycle, 1 after; cycle_count counts from 0.
- LBI/ADDI/R-type: LBI r1,#5; LBI r2,#-3; ADD r3,r1,r2 → write_reg 1/0x0005, 2/0xFFFD, 3/0x0002; SUB gives r2-r1=0xFFF8.
- Memory: LBI r1,#0x10; LBI r2,#0x55; ST r2,r1,#2; LD r4,r1,#2 → store dmem_wen=1, addr 0x0012, data 0x0055; load reg_write r4=0x0055.
- Branch: LBI r1,#0; BEQZ r1,#4 → next cycle valid_ifid=0 and pc=target; skipped instruction writes nothing. BEQZ on nonzero falls through with no flush.
- J: J #-2 at addr 0 → loops to 0; cycle-exact pc sequence 0,2,0,2…
- Halt: LBI r1,#7; HALT; ADDI r1,r1,#1 → halt=1 one cycle after HALT is fetched; r1 stays 0x0007; halt stays high and pc frozen afterward; async rst clears halt.
